wb_arbiter: RTL and testbench

Writeback arbiter between the execute-stage functional units and the integer register file. Each cycle it takes at most one result from the arithmetic unit (`wdata_au` path) and at most one from the load/store unit. It commits exactly one register-file write per cycle through a registered output. AU results that lose arbitration to the LSU are held in a small in-order FIFO, and upstream issue is back-pressured when that FIFO is full.

---
 rtl/wb_arbiter_if.sv | 41 ++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of the writeback arbiter's functional-unit inputs
// and register-file outputs.
//   au_*      : arithmetic-unit result and its ready back-pressure
//   lsu_*     : load/store-unit load result (never back-pressured)
//   flush     : discard buffered, uncommitted AU results
//   rf_*      : registered register-file write port
//   fifo_count: number of buffered AU results
// Modports: master drives the inputs and observes the outputs (execute
// stage / bench); slave is the arbiter itself.
interface wb_arbiter_if #(
    parameter int AU_FIFO_DEPTH = 2,
    parameter int WORD_SIZE     = 32
);
    localparam int CNT_W = $clog2(AU_FIFO_DEPTH) + 1;

    logic                 au_valid;
    logic                 au_wen;
    logic [4:0]           au_rd;
    logic [WORD_SIZE-1:0] au_wdata;
    logic                 au_ready;
    logic                 lsu_valid;
    logic [4:0]           lsu_rd;
    logic [WORD_SIZE-1:0] lsu_wdata;
    logic                 flush;
    logic                 rf_wen;
    logic [4:0]           rf_rd;
    logic [WORD_SIZE-1:0] rf_wdata;
    logic [CNT_W-1:0]     fifo_count;

    modport master (
        output au_valid, au_wen, au_rd, au_wdata,
        output lsu_valid, lsu_rd, lsu_wdata, flush,
        input  au_ready, rf_wen, rf_rd, rf_wdata, fifo_count
    );

    modport slave (
        input  au_valid, au_wen, au_rd, au_wdata,
        input  lsu_valid, lsu_rd, lsu_wdata, flush,
        output au_ready, rf_wen, rf_rd, rf_wdata, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: commits one integer register-file write per cycle, choosing
// between the LSU load result, the oldest buffered AU result and a bypassed
// incoming AU result (in that priority). AU results that lose to the LSU wait
// in an in-order circular FIFO; au_ready back-pressures issue when it is full.
// Ports:
//   CLK  : clock, all state on the rising edge
//   nRST : asynchronous active-low reset
//   bus  : wb_arbiter_if.slave (AU/LSU inputs, flush, rf_* outputs,
//          au_ready, fifo_count)
module wb_arbiter #(
    parameter int AU_FIFO_DEPTH = 2,
    parameter int WORD_SIZE     = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(AU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(AU_FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]           rd;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    entry_t               mem [AU_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 rf_wen_q;
    logic [4:0]           rf_rd_q;
    logic [WORD_SIZE-1:0] rf_wdata_q;

    logic   lsu_take, fifo_empty, head_pop, ready;
    logic   au_live, bypass, push, sel_valid;
    entry_t sel_entry, au_entry;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        // A zero-destination load is filtered before selection, so it never
        // occupies the write port.
        lsu_take   = bus.lsu_valid && (bus.lsu_rd != 5'd0);
        fifo_empty = (count == '0);
        head_pop   = !lsu_take && !fifo_empty;
        // A slot frees when the head leaves this cycle, so a full FIFO can
        // still accept. Flush blocks the AU input outright.
        ready      = !bus.flush && ((count < DEPTH_C) || head_pop);
        au_live    = bus.au_valid && ready && bus.au_wen && (bus.au_rd != 5'd0);
        // Bypass only with an empty FIFO so AU results stay in issue order.
        bypass     = au_live && !lsu_take && fifo_empty;
        push       = au_live && !bypass;
        au_entry   = '{rd: bus.au_rd, data: bus.au_wdata};

        sel_valid  = 1'b0;
        sel_entry  = '0;
        if (lsu_take) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: bus.lsu_rd, data: bus.lsu_wdata};
        end else if (head_pop) begin
            // The head still leaves during a flush but is not written.
            sel_valid = !bus.flush;
            sel_entry = mem[rd_ptr];
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_entry = au_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Power-of-two depth: pointers wrap by natural overflow.
                if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
                if (head_pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, head_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
            rf_wen_q <= sel_valid;
            if (sel_valid) begin
                rf_rd_q    <= sel_entry.rd;
                rf_wdata_q <= sel_entry.data;
            end
        end
    end

    // NOTE: the storage array has no reset; count and pointers define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= au_entry;
    end

    assign bus.au_ready   = ready;
    assign bus.fifo_count = count;
    assign bus.rf_wen     = rf_wen_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, an asynchronous mid-stream reset
// sequence, then randomized traffic compared against a queue-based model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int WS    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.AU_FIFO_DEPTH(DEPTH), .WORD_SIZE(WS)) bus ();

    wb_arbiter #(.AU_FIFO_DEPTH(DEPTH), .WORD_SIZE(WS)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        au_valid, au_wen;
        logic [4:0]  au_rd;
        logic [31:0] au_wdata;
        logic        lsu_valid;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_wdata;
        logic        flush;
        logic        exp_ready, exp_wen;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wdata;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pending AU results as a queue plus the write port.
    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic aw, input logic [4:0] ar,
                                input logic [31:0] ad, input logic lv, input logic [4:0] lr,
                                input logic [31:0] ld, input logic fl, input logic er,
                                input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                                input int ec);
        vec_t v;
        v.au_valid = av; v.au_wen = aw; v.au_rd = ar; v.au_wdata = ad;
        v.lsu_valid = lv; v.lsu_rd = lr; v.lsu_wdata = ld; v.flush = fl;
        v.exp_ready = er; v.exp_wen = ew; v.exp_rd = erd; v.exp_wdata = ed;
        v.exp_cnt = ec;
        return v;
    endfunction

    task automatic drive_idle();
        bus.au_valid = 0; bus.au_wen = 0; bus.au_rd = '0; bus.au_wdata = '0;
        bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_wdata = '0; bus.flush = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_wen = 0; m_rd = '0; m_data = '0;
    endtask

    // Apply one cycle of stimulus, advance the model, and compare either
    // against the vector's own expectations or against the model.
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        bit   lt, pop, live, used;
        logic m_ready;
        ent_t e;
        @(negedge clk);
        bus.au_valid = v.au_valid; bus.au_wen = v.au_wen;
        bus.au_rd = v.au_rd; bus.au_wdata = v.au_wdata;
        bus.lsu_valid = v.lsu_valid; bus.lsu_rd = v.lsu_rd;
        bus.lsu_wdata = v.lsu_wdata; bus.flush = v.flush;

        lt      = v.lsu_valid && (v.lsu_rd != 0);
        pop     = !lt && (mq.size() != 0);
        m_ready = !v.flush && ((mq.size() < DEPTH) || pop);
        live    = v.au_valid && m_ready && v.au_wen && (v.au_rd != 0);
        used    = 0;
        m_wen   = 0;
        if (lt) begin
            m_wen = 1; m_rd = v.lsu_rd; m_data = v.lsu_wdata;
        end else if (pop) begin
            if (!v.flush) begin
                m_wen = 1; m_rd = mq[0].rd; m_data = mq[0].data;
            end
        end else if (live) begin
            m_wen = 1; m_rd = v.au_rd; m_data = v.au_wdata; used = 1;
        end
        if (v.flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (live && !used) begin
                e.rd = v.au_rd; e.data = v.au_wdata;
                mq.push_back(e);
            end
        end

        #1;
        check({tag, " au_ready"}, 64'(bus.au_ready), use_tbl ? 64'(v.exp_ready) : 64'(m_ready));
        @(posedge clk);
        #1;
        if (use_tbl) begin
            check({tag, " rf_wen"},     64'(bus.rf_wen),     64'(v.exp_wen));
            check({tag, " rf_rd"},      64'(bus.rf_rd),      64'(v.exp_rd));
            check({tag, " rf_wdata"},   64'(bus.rf_wdata),   64'(v.exp_wdata));
            check({tag, " fifo_count"}, 64'(bus.fifo_count), 64'(v.exp_cnt));
        end else begin
            check({tag, " rf_wen"},     64'(bus.rf_wen),     64'(m_wen));
            check({tag, " rf_rd"},      64'(bus.rf_rd),      64'(m_rd));
            check({tag, " rf_wdata"},   64'(bus.rf_wdata),   64'(m_data));
            check({tag, " fifo_count"}, 64'(bus.fifo_count), 64'(mq.size()));
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        // au_v wen rd data | lsu_v rd data | flush | ready | wen rd data | count
        tbl.push_back(mk(1,1, 5,32'h12345678, 0, 0,32'h0,       0, 1, 1, 5,32'h12345678,0));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 0, 5,32'h12345678,0));
        tbl.push_back(mk(1,1, 4,32'h44,       1, 3,32'hAAAA0000,0, 1, 1, 3,32'hAAAA0000,1));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 1, 4,32'h44,      0));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 0, 4,32'h44,      0));
        tbl.push_back(mk(1,1,10,32'hA0,       1,20,32'h2000,    0, 1, 1,20,32'h2000,    1));
        tbl.push_back(mk(1,1,11,32'hB0,       1,21,32'h2100,    0, 1, 1,21,32'h2100,    2));
        tbl.push_back(mk(1,1,12,32'hC0,       1,22,32'h2200,    0, 0, 1,22,32'h2200,    2));
        tbl.push_back(mk(1,1,12,32'hC0,       1,23,32'h2300,    0, 0, 1,23,32'h2300,    2));
        tbl.push_back(mk(1,1,12,32'hC0,       0, 0,32'h0,       0, 1, 1,10,32'hA0,      2));
        tbl.push_back(mk(1,1,13,32'hD0,       0, 0,32'h0,       0, 1, 1,11,32'hB0,      2));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 1,12,32'hC0,      1));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 1,13,32'hD0,      0));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 0,13,32'hD0,      0));
        tbl.push_back(mk(1,1,14,32'hE0,       1,24,32'h2400,    0, 1, 1,24,32'h2400,    1));
        tbl.push_back(mk(1,1,15,32'hF0,       1,25,32'h2500,    0, 1, 1,25,32'h2500,    2));
        tbl.push_back(mk(1,1,16,32'h160,      1, 7,32'h77,      1, 0, 1, 7,32'h77,      0));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 0, 7,32'h77,      0));
        tbl.push_back(mk(1,1,17,32'h170,      1,26,32'h2600,    0, 1, 1,26,32'h2600,    1));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       1, 0, 0,26,32'h2600,    0));
        tbl.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,       0, 1, 0,26,32'h2600,    0));
        tbl.push_back(mk(1,1, 0,32'hBAD,      0, 0,32'h0,       0, 1, 0,26,32'h2600,    0));
        tbl.push_back(mk(1,0, 9,32'hBAD0,     0, 0,32'h0,       0, 1, 0,26,32'h2600,    0));
        tbl.push_back(mk(1,1,18,32'h180,      1,27,32'h2700,    0, 1, 1,27,32'h2700,    1));
        tbl.push_back(mk(1,1, 0,32'hDEAD,     0, 0,32'h0,       0, 1, 1,18,32'h180,     0));
        tbl.push_back(mk(0,0, 0,32'h0,        1, 0,32'h5555,    0, 1, 0,18,32'h180,     0));
        tbl.push_back(mk(1,1,19,32'h190,      1,28,32'h2800,    0, 1, 1,28,32'h2800,    1));
        tbl.push_back(mk(1,1,20,32'h200,      1,29,32'h2900,    0, 1, 1,29,32'h2900,    2));

        drive_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rf_wen",     64'(bus.rf_wen),     64'd0);
        check("reset rf_rd",      64'(bus.rf_rd),      64'd0);
        check("reset rf_wdata",   64'(bus.rf_wdata),   64'd0);
        check("reset fifo_count", 64'(bus.fifo_count), 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("tbl[%0d]", i));

        // Asynchronous reset in mid-cycle with two buffered AU results.
        @(negedge clk);
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst rf_wen",     64'(bus.rf_wen),     64'd0);
        check("mid_rst rf_rd",      64'(bus.rf_rd),      64'd0);
        check("mid_rst rf_wdata",   64'(bus.rf_wdata),   64'd0);
        check("mid_rst fifo_count", 64'(bus.fifo_count), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(mk(1,1,30,32'h3030, 0,0,32'h0, 0, 1, 1,30,32'h3030,0), 1'b1, "post_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            v.au_valid  = ($urandom_range(0, 9) < 7);
            v.au_wen    = ($urandom_range(0, 9) < 9);
            v.au_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.au_wdata  = $urandom;
            v.lsu_valid = ($urandom_range(0, 9) < 4);
            v.lsu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.lsu_wdata = $urandom;
            v.flush     = ($urandom_range(0, 19) == 0);
            v.exp_ready = 0; v.exp_wen = 0; v.exp_rd = '0; v.exp_wdata = '0; v.exp_cnt = 0;
            run_cycle(v, 1'b0, $sformatf("rnd[%0d]", n));
        end

        @(negedge clk);
        drive_idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
